// File: rtl/btn_inst_issue_pkg.sv
// Shared defaults, counter type and sizing helper for the front-panel instruction issuer.
package btn_inst_issue_pkg;

    localparam int DEF_NUM_BTN    = 2;
    localparam int DEF_INST_W     = 8;
    localparam int DEF_DIV_W      = 17;
    localparam int DEF_STABLE_N   = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_PREFIX_W   = 2;

    // Wide enough for the largest legal button count and prefix width.
    localparam logic [7:0]  DEF_BTN_RAW_MASK = 8'b0000_0001;
    localparam logic [63:0] DEF_BTN_PREFIX   = 64'h0000_0000_0000_000C;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = 8'hFF;

    // Ceiling log2, never below 1 so index vectors always have a bit.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/btn_inst_issue_debounce.sv
// One button: 2-flop synchroniser, tick-sampled history, accepted level and a 1-clk press pulse.
module btn_inst_issue_debounce
    import btn_inst_issue_pkg::*;
#(
    parameter int STABLE_N = DEF_STABLE_N
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_press
);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [STABLE_N-2:0] hist_q, hist_d;
    logic [STABLE_N-1:0] window_s;
    logic                level_q, level_d;
    logic                press_q, press_d;

    // Previous STABLE_N-1 samples plus the current one form the stability window.
    always_comb begin
        sync1_d  = i_btn;
        sync2_d  = sync1_q;
        window_s = {hist_q, sync2_q};
        hist_d   = hist_q;
        level_d  = level_q;
        press_d  = 1'b0;
        if (i_tick) begin
            hist_d = window_s[STABLE_N-2:0];
            if ((&window_s) && !level_q) begin
                level_d = 1'b1;
                press_d = 1'b1;
            end else if (!(|window_s) && level_q) begin
                level_d = 1'b0;
                press_d = 1'b0;
            end else begin
                level_d = level_q;
                press_d = 1'b0;
            end
        end else begin
            hist_d  = hist_q;
            level_d = level_q;
            press_d = 1'b0;
        end
    end

    // Synchroniser, history and accepted-level state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/btn_inst_issue.sv
// Front-panel instruction issuer: debounced buttons become instruction words queued in a FIFO
// and handed to the sequencer over valid/ready, with issue and drop counters.
module btn_inst_issue
    import btn_inst_issue_pkg::*;
#(
    parameter int                           NUM_BTN      = DEF_NUM_BTN,
    parameter int                           INST_W       = DEF_INST_W,
    parameter int                           DIV_W        = DEF_DIV_W,
    parameter int                           STABLE_N     = DEF_STABLE_N,
    parameter int                           FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int                           PREFIX_W     = DEF_PREFIX_W,
    parameter logic [NUM_BTN-1:0]           BTN_RAW_MASK = DEF_BTN_RAW_MASK[NUM_BTN-1:0],
    parameter logic [NUM_BTN*PREFIX_W-1:0]  BTN_PREFIX   = DEF_BTN_PREFIX[NUM_BTN*PREFIX_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_BTN-1:0] i_btn,
    input  logic [INST_W-1:0] i_sw,
    output logic [INST_W-1:0] o_inst,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [CNT_W-1:0]  o_inst_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    localparam int AW     = log2_ceil(FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam int BIDX_W = log2_ceil(NUM_BTN);
    localparam int LOW_W  = INST_W - PREFIX_W;

    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_s;
    logic [INST_W-1:0]   sw_sync1_q, sw_sync1_d;
    logic [INST_W-1:0]   sw_sync2_q, sw_sync2_d;
    logic [INST_W-1:0]   sw_dly_q, sw_dly_d;
    logic [INST_W-1:0]   sw_cap_q, sw_cap_d;
    logic [NUM_BTN-1:0]  press_s;
    logic [NUM_BTN-1:0]  pending_q, pending_d;
    logic [NUM_BTN-1:0]  grant_oh_s;
    logic [BIDX_W-1:0]   grant_idx_s;
    logic                push_req_s;
    logic [PREFIX_W-1:0] prefix_s;
    logic [INST_W-1:0]   word_s;
    logic [INST_W-1:0]   mem_q [FIFO_DEPTH];
    logic [INST_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                empty_s, full_s, pop_s, push_s, drop_s;
    cnt_t                inst_cnt_q, inst_cnt_d;
    cnt_t                drop_cnt_q, drop_cnt_d;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_inst_issue_debounce #(
            .STABLE_N (STABLE_N)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (tick_s),
            .i_btn   (i_btn[b]),
            .o_press (press_s[b])
        );
    end

    assign tick_s = &div_q;

    // Divider and switch path. The press pulse lags the accepting tick by one clk, so the
    // extra delay stage hands sw_cap the value the synchroniser held at that tick.
    always_comb begin
        div_d      = div_q + DIV_W'(1);
        sw_sync1_d = i_sw;
        sw_sync2_d = sw_sync1_q;
        sw_dly_d   = sw_sync2_q;
        if (|press_s) begin
            sw_cap_d = sw_dly_q;
        end else begin
            sw_cap_d = sw_cap_q;
        end
    end

    // Lowest pending button wins; its word is either raw switches or prefixed low bits.
    always_comb begin
        grant_idx_s = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            grant_idx_s = pending_q[i] ? BIDX_W'(i) : grant_idx_s;
        end
        push_req_s = |pending_q;
        grant_oh_s = pending_q & (~pending_q + NUM_BTN'(1));
        prefix_s   = BTN_PREFIX[int'(grant_idx_s) * PREFIX_W +: PREFIX_W];
        if (BTN_RAW_MASK[grant_idx_s]) begin
            word_s = sw_cap_q;
        end else begin
            word_s = {prefix_s, sw_cap_q[LOW_W-1:0]};
        end
        pending_d = (pending_q & ~grant_oh_s) | press_s;
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in the same clk.
    always_comb begin
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s    = !empty_s && i_inst_ready;
        push_s   = push_req_s && (!full_s || pop_s);
        drop_s   = push_req_s && full_s && !pop_s;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = word_s;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Issue counter wraps; drop counter sticks at its maximum.
    always_comb begin
        inst_cnt_d = inst_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pop_s) begin
            inst_cnt_d = inst_cnt_q + 8'd1;
        end else begin
            inst_cnt_d = inst_cnt_q;
        end
        if (drop_s && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Divider, switch synchroniser and arbitration state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            sw_dly_q   <= '0;
            sw_cap_q   <= '0;
            pending_q  <= '0;
        end else begin
            div_q      <= div_d;
            sw_sync1_q <= sw_sync1_d;
            sw_sync2_q <= sw_sync2_d;
            sw_dly_q   <= sw_dly_d;
            sw_cap_q   <= sw_cap_d;
            pending_q  <= pending_d;
        end
    end

    // FIFO storage, pointers and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inst_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inst_cnt_q <= inst_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_inst_valid = !empty_s;
    assign o_inst       = empty_s ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign o_inst_cnt   = inst_cnt_q;
    assign o_drop_cnt   = drop_cnt_q;

endmodule
